// File: rtl/route_sched.sv
// rtl/route_sched.sv - station route scheduler between UART receiver and command controller
module route_sched #(
    parameter int DEPTH     = 4,
    parameter int DWELL_CYC = 50_000_000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               i_rx_cmd,
    input  logic                     i_rx_rdy,
    output logic                     o_clr_rx_rdy,
    output logic [7:0]               o_cmd,
    output logic                     o_cmd_rdy,
    input  logic                     i_clr_cmd_rdy,
    input  logic                     i_in_transit,
    output logic                     o_busy,
    output logic [$clog2(DEPTH):0]   o_q_cnt,
    output logic                     o_ovf,
    output logic                     o_arrived,
    output logic                     o_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = $clog2(DWELL_CYC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_TRANSIT,
        S_DWELL,
        S_ABORT
    } state_t;

    state_t          r_state;
    logic            r_clr_rx_rdy;
    logic [7:0]      r_cmd;
    logic            r_cmd_rdy;
    logic            r_busy;
    logic            r_arrived;
    logic            r_done;
    logic            r_running;
    logic            r_abort_low;
    logic [DW-1:0]   r_dwell;
    logic [CW-1:0]   r_q_cnt;
    logic            r_ovf;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [5:0]      r_mem [DEPTH];

    logic            w_rx_acc;
    logic [1:0]      w_op;
    logic            w_push;
    logic            w_start;
    logic            w_abort;
    logic            w_full;
    logic            w_push_ok;
    logic            w_pop;
    logic            w_finish;
    logic            w_running_nxt;
    logic [5:0]      w_head;

    // A held rx_rdy is taken once; the consume pulse masks it for the following cycle.
    assign w_rx_acc  = i_rx_rdy && !r_clr_rx_rdy;
    assign w_op      = i_rx_cmd[7:6];
    assign w_push    = w_rx_acc && (w_op == 2'b01);
    assign w_start   = w_rx_acc && (w_op == 2'b10);
    assign w_abort   = w_rx_acc && (w_op == 2'b00);

    // Full is judged on the count before this cycle, even if a pop happens alongside.
    assign w_full    = (r_q_cnt == CW'(DEPTH));
    assign w_push_ok = w_push && !w_full;

    // Abort outranks both dispatch and route completion.
    assign w_pop     = (r_state == S_IDLE) && r_running && (r_q_cnt != '0) && !w_abort;
    assign w_finish  = (r_state == S_IDLE) && r_running && (r_q_cnt == '0) && !w_abort;
    assign w_running_nxt = !w_abort && !w_finish && (r_running || w_start);

    assign w_head    = r_mem[r_rd_ptr];

    // Consume pulse back to the UART for every accepted command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clr_rx_rdy <= 1'b0;
        end else begin
            r_clr_rx_rdy <= w_rx_acc;
        end
    end

    // Queue storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_rx_cmd[5:0];
        end
    end

    // Queue pointers, occupancy and sticky overflow; abort flushes everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_q_cnt  <= '0;
            r_ovf    <= 1'b0;
        end else if (w_abort) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_q_cnt  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push_ok && !w_pop) begin
                r_q_cnt <= r_q_cnt + CW'(1);
            end else if (!w_push_ok && w_pop) begin
                r_q_cnt <= r_q_cnt - CW'(1);
            end
            if (w_push && w_full) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Route FSM: dispatch, wait for the leg, dwell, and controlled stop on abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cmd       <= 8'h00;
            r_cmd_rdy   <= 1'b0;
            r_busy      <= 1'b0;
            r_arrived   <= 1'b0;
            r_done      <= 1'b0;
            r_running   <= 1'b0;
            r_abort_low <= 1'b0;
            r_dwell     <= '0;
        end else begin
            r_arrived <= 1'b0;
            r_done    <= 1'b0;
            r_running <= w_running_nxt;
            if (w_abort) begin
                r_dwell     <= '0;
                r_abort_low <= 1'b0;
                if (r_state == S_ISSUE || r_state == S_TRANSIT || r_state == S_ABORT) begin
                    // The vehicle may be moving: hold a stop command until it is taken.
                    r_state   <= S_ABORT;
                    r_cmd     <= 8'h00;
                    r_cmd_rdy <= 1'b1;
                    r_busy    <= 1'b1;
                end else begin
                    r_state   <= S_IDLE;
                    r_cmd_rdy <= 1'b0;
                    r_busy    <= 1'b0;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_pop) begin
                            r_cmd     <= {2'b01, w_head};
                            r_cmd_rdy <= 1'b1;
                            r_state   <= S_ISSUE;
                            r_busy    <= 1'b1;
                        end else begin
                            if (w_finish) begin
                                r_done <= 1'b1;
                            end
                            r_busy <= w_running_nxt;
                        end
                    end
                    S_ISSUE: begin
                        if (i_clr_cmd_rdy || i_in_transit) begin
                            r_cmd_rdy <= 1'b0;
                        end
                        if (i_in_transit) begin
                            r_state <= S_TRANSIT;
                        end
                    end
                    S_TRANSIT: begin
                        if (!i_in_transit) begin
                            r_arrived <= 1'b1;
                            r_dwell   <= DW'(DWELL_CYC - 1);
                            r_state   <= S_DWELL;
                        end
                    end
                    S_DWELL: begin
                        if (r_dwell == '0) begin
                            r_state <= S_IDLE;
                            r_busy  <= w_running_nxt;
                        end else begin
                            r_dwell <= r_dwell - DW'(1);
                        end
                    end
                    S_ABORT: begin
                        // Leave when the stop is consumed, or the vehicle is seen stationary twice in a row.
                        if (i_clr_cmd_rdy || (!i_in_transit && r_abort_low)) begin
                            r_state     <= S_IDLE;
                            r_cmd_rdy   <= 1'b0;
                            r_busy      <= w_running_nxt;
                            r_abort_low <= 1'b0;
                        end else begin
                            r_abort_low <= !i_in_transit;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_clr_rx_rdy = r_clr_rx_rdy;
    assign o_cmd        = r_cmd;
    assign o_cmd_rdy    = r_cmd_rdy;
    assign o_busy       = r_busy;
    assign o_q_cnt      = r_q_cnt;
    assign o_ovf        = r_ovf;
    assign o_arrived    = r_arrived;
    assign o_done       = r_done;

endmodule
